// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to a fixed pool of oscillator voices.
// Each accepted event is scanned across all voices one per cycle. The event is
// then committed in a single cycle, which either allocates, retriggers, frees
// or drops a voice.
// Optional build macro: VOICE_STEAL_EN. When it is defined, a note-on that
// arrives with every voice busy takes over the oldest voice instead of being
// dropped.
module voice_allocator #(
  parameter int N_VOICES = 8,
  parameter int PITCH_W  = 6,
  parameter int VEL_W    = 8,
  parameter int AGE_W    = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_note_on,
  input  logic [PITCH_W-1:0]            ev_pitch,
  input  logic [VEL_W-1:0]              ev_velocity,
  output logic                          ev_dropped,
  output logic [N_VOICES-1:0]           voice_active,
  output logic [N_VOICES*PITCH_W-1:0]   voice_pitch,
  output logic [N_VOICES*VEL_W-1:0]     voice_velocity,
  output logic [N_VOICES-1:0]           voice_env_reset
);

  localparam int IDX_W = $clog2(N_VOICES);
  localparam logic [PITCH_W-1:0] SILENT = PITCH_W'(36);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t               state_reg, state_next;
  logic                 ready_reg, ready_next;
  logic [IDX_W-1:0]     idx_reg;
  logic                 lat_on_reg;
  logic [PITCH_W-1:0]   lat_pitch_reg;
  logic [VEL_W-1:0]     lat_vel_reg;
  logic                 match_found_reg, free_found_reg;
  logic [IDX_W-1:0]     match_idx_reg, free_idx_reg;
`ifdef VOICE_STEAL_EN
  logic                 old_found_reg;
  logic [IDX_W-1:0]     old_idx_reg;
  logic [AGE_W-1:0]     old_age_reg;
`endif

  logic [N_VOICES-1:0]  active_reg;
  logic [PITCH_W-1:0]   pitch_reg [N_VOICES];
  logic [VEL_W-1:0]     vel_reg   [N_VOICES];
  logic [AGE_W-1:0]     age_reg   [N_VOICES];
  logic [N_VOICES-1:0]  env_reset_reg;
  logic                 dropped_reg;

  logic                 accept;
  logic                 wr_on, wr_off, drop;
  logic [IDX_W-1:0]     target;

  // ev_ready is registered so that it stays low while reset is held.
  assign accept   = ev_valid && ready_reg;
  assign ev_ready = ready_reg;

  // State register and registered ready flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
    end
  end

  // Next-state logic: IDLE -> SCAN (N_VOICES cycles) -> COMMIT -> IDLE.
  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    case (state_reg)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (idx_reg == IDX_W'(N_VOICES - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE);
  end

  // Latch the event on accept, then walk the voices and record candidates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_on_reg      <= 1'b0;
      lat_pitch_reg   <= SILENT;
      lat_vel_reg     <= '0;
      idx_reg         <= '0;
      match_found_reg <= 1'b0;
      match_idx_reg   <= '0;
      free_found_reg  <= 1'b0;
      free_idx_reg    <= '0;
`ifdef VOICE_STEAL_EN
      old_found_reg   <= 1'b0;
      old_idx_reg     <= '0;
      old_age_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          lat_on_reg      <= ev_note_on;
          lat_pitch_reg   <= ev_pitch;
          lat_vel_reg     <= ev_velocity;
          idx_reg         <= '0;
          match_found_reg <= 1'b0;
          free_found_reg  <= 1'b0;
`ifdef VOICE_STEAL_EN
          old_found_reg   <= 1'b0;
          old_age_reg     <= '0;
`endif
        end
        SCAN: begin
          if (active_reg[idx_reg]) begin
            if (!match_found_reg && pitch_reg[idx_reg] == lat_pitch_reg) begin
              match_found_reg <= 1'b1;
              match_idx_reg   <= idx_reg;
            end
`ifdef VOICE_STEAL_EN
            // Strict '>' keeps the lowest index on an age tie.
            if (!old_found_reg || age_reg[idx_reg] > old_age_reg) begin
              old_found_reg <= 1'b1;
              old_idx_reg   <= idx_reg;
              old_age_reg   <= age_reg[idx_reg];
            end
`endif
          end else if (!free_found_reg) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= idx_reg;
          end
          idx_reg <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Commit decision: choose the target voice, or drop the event.
  always_comb begin
    wr_on  = 1'b0;
    wr_off = 1'b0;
    drop   = 1'b0;
    target = '0;
    if (state_reg == COMMIT) begin
      if (lat_on_reg) begin
        if (lat_pitch_reg == SILENT) begin
          drop = 1'b1;
        end else if (match_found_reg) begin
          wr_on  = 1'b1;
          target = match_idx_reg;
        end else if (free_found_reg) begin
          wr_on  = 1'b1;
          target = free_idx_reg;
        end else begin
`ifdef VOICE_STEAL_EN
          wr_on  = 1'b1;
          target = old_idx_reg;
`else
          drop   = 1'b1;
`endif
        end
      end else if (match_found_reg) begin
        wr_off = 1'b1;
        target = match_idx_reg;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Voice state updates; ages only advance on a successful note-on commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_reg    <= '0;
      env_reset_reg <= '0;
      dropped_reg   <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        pitch_reg[i] <= SILENT;
        vel_reg[i]   <= '0;
        age_reg[i]   <= '0;
      end
    end else begin
      dropped_reg <= drop;
      for (int i = 0; i < N_VOICES; i++) begin
        env_reset_reg[i] <= wr_on && (target == IDX_W'(i));
        if (wr_on && target == IDX_W'(i)) begin
          active_reg[i] <= 1'b1;
          pitch_reg[i]  <= lat_pitch_reg;
          vel_reg[i]    <= lat_vel_reg;
          age_reg[i]    <= '0;
        end else if (wr_on && active_reg[i] && age_reg[i] != {AGE_W{1'b1}}) begin
          age_reg[i] <= age_reg[i] + 1'b1;
        end else if (wr_off && target == IDX_W'(i)) begin
          active_reg[i] <= 1'b0;
          pitch_reg[i]  <= SILENT;
        end
      end
    end
  end

  assign voice_active    = active_reg;
  assign voice_env_reset = env_reset_reg;
  assign ev_dropped      = dropped_reg;

  // Pack the per-voice arrays onto the flat output buses.
  generate
    for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_pack
      assign voice_pitch[gi*PITCH_W +: PITCH_W]  = pitch_reg[gi];
      assign voice_velocity[gi*VEL_W +: VEL_W]   = vel_reg[gi];
    end
  endgenerate

endmodule
